uart_sync_fifo: RTL

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_ram.sv | 25 ++
 rtl/uart_sync_fifo.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default word width and receive/transmit FIFO depth.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the UART FIFO: one synchronous write port,
// one asynchronous read port, no reset on the array.
module uart_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO: pointers, occupancy count, flag decode, sticky
// error flags and a selectable registered / first-word-fall-through output.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH    = UART_DATA_W,
    parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A rejected write while full also freezes the read side for that cycle.
    always_comb begin
        wr_acc   = wr_en && !full && !flush;
        rd_acc   = rd_en && !empty && !flush && !(wr_en && full);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full & ~flush);
        unf_d    = unf_q | (rd_en & empty & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    if (FWFT) begin : g_fwft
        // Head entry shown directly; zero while nothing is stored.
        assign dout  = empty ? '0 : rd_data;
        assign valid = !empty;
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;
        logic             valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) dout_q <= rd_data;
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end

endmodule
